// File: rtl/rd_mngr_pkg.sv
// rd_mngr_pkg: shared state types, response code and priority helper for read_outstanding_mngr
package rd_mngr_pkg;
   typedef enum logic [1:0] {SLOT_FREE, SLOT_WAIT, SLOT_DONE} slot_st_t;
   typedef enum logic [1:0] {AR_IDLE, AR_REQ, AR_ADDR} ar_st_t;
   localparam logic [1:0] RRESP_OKAY = 2'b00;
   function automatic int lowest_set(input logic [31:0] v);
      lowest_set = 0;
      for (int i = 31; i >= 0; i--)
         if (v[i]) lowest_set = i;
   endfunction
endpackage

// File: rtl/rd_slot_buf.sv
// rd_slot_buf: one outstanding-read slot; line buffer, beat counter, sticky error flag and slot state
module rd_slot_buf
   import rd_mngr_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int BEATS  = 4
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alloc,
   input  logic                     free,
   input  logic                     beat_en,
   input  logic [DATA_W-1:0]        rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   output logic [1:0]               st,
   output logic                     err,
   output logic [DATA_W*BEATS-1:0]  line
);
   localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
   slot_st_t state;
   logic [CW-1:0] cnt;
   logic [BEATS-1:0][DATA_W-1:0] lbuf;
   logic last_cnt;
   assign last_cnt = cnt == CW'(BEATS - 1);
   assign st = state;
   assign line = lbuf;
   // an rlast that disagrees with the beat count in either direction flags the line and closes it
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= SLOT_FREE;
         cnt <= '0;
         err <= 1'b0;
         lbuf <= '0;
      end else if (state == SLOT_FREE) begin
         if (alloc) begin
            state <= SLOT_WAIT;
            cnt <= '0;
            err <= 1'b0;
         end
      end else if (state == SLOT_DONE) begin
         if (free) state <= SLOT_FREE;
      end else if (beat_en) begin
         lbuf[cnt] <= rdata;
         cnt <= cnt + 1'b1;
         if (rresp != RRESP_OKAY || rlast != last_cnt) err <= 1'b1;
         if (rlast || last_cnt) state <= SLOT_DONE;
      end
endmodule

// File: rtl/read_outstanding_mngr.sv
// read_outstanding_mngr: multi-outstanding AXI-style line read master with per-slot line assembly.
// Define RD_INORDER_EN to return lines in issue order; otherwise the lowest-index finished slot goes first.
module read_outstanding_mngr
   import rd_mngr_pkg::*;
#(
   parameter logic [1:0] M_ID = 2'b00,
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEATS  = 4,
   parameter int OUTSTD = 2
)(
   input  logic                     clk,
   input  logic                     rst,
   output logic                     req_rq,
   input  logic                     gnt_rq,
   output logic                     arvalid,
   input  logic                     arready,
   output logic [ID_W-1:0]          arid,
   output logic [ADDR_W-1:0]        araddr,
   output logic [7:0]               arlen,
   input  logic                     rvalid,
   output logic                     rready,
   input  logic [ID_W-1:0]          rid,
   input  logic [DATA_W-1:0]        rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic                     rstart_rq,
   input  logic [ADDR_W-1:0]        rin_addr,
   output logic                     rbusy,
   output logic [ID_W-3:0]          rq_slot,
   output logic [DATA_W*BEATS-1:0]  rdat_m_data,
   output logic [ID_W-3:0]          rdat_m_slot,
   output logic                     rdat_m_err,
   output logic                     rdat_m_valid,
   input  logic                     rdat_m_ready,
   output logic                     finish_mrd
);
   localparam int SW = ID_W - 2;
   localparam int OFF = $clog2(BEATS * DATA_W / 8);
   localparam logic [ADDR_W-1:0] AMASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
   ar_st_t ar_st;
   logic [OUTSTD-1:0] free_vec, done_vec, alloc, rel, beat_hit, err_v;
   logic [1:0] st [OUTSTD];
   logic [DATA_W*BEATS-1:0] line_v [OUTSTD];
   logic [DATA_W*BEATS-1:0] sel_line;
   logic accept, hs, pick, sel_ok, sel_err, idle_now, idle_q;
   logic [SW-1:0] nxt;
   assign rready = rvalid & (rid[ID_W-1 -: 2] == M_ID);
   assign rbusy = (ar_st != AR_IDLE) | ~|free_vec;
   assign rq_slot = SW'(lowest_set(32'(free_vec)));
   assign accept = rstart_rq & ~rbusy;
   assign arlen = 8'(BEATS - 1);
   assign hs = rdat_m_valid & rdat_m_ready;
   assign idle_now = &free_vec & (ar_st == AR_IDLE);
   for (genvar i = 0; i < OUTSTD; i++) begin : g_slot
      assign free_vec[i] = st[i] == SLOT_FREE;
      assign done_vec[i] = st[i] == SLOT_DONE;
      assign alloc[i] = accept && rq_slot == SW'(i);
      assign rel[i] = hs && rdat_m_slot == SW'(i);
      assign beat_hit[i] = rready && rid[SW-1:0] == SW'(i);
      rd_slot_buf #(.DATA_W(DATA_W), .BEATS(BEATS)) u_buf (
         .clk(clk), .rst(rst), .alloc(alloc[i]), .free(rel[i]), .beat_en(beat_hit[i]),
         .rdata(rdata), .rresp(rresp), .rlast(rlast),
         .st(st[i]), .err(err_v[i]), .line(line_v[i])
      );
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ar_st <= AR_IDLE;
         req_rq <= 1'b0;
         arvalid <= 1'b0;
         arid <= '0;
         araddr <= '0;
      end else
         case (ar_st)
            AR_IDLE: if (accept) begin
               ar_st <= AR_REQ;
               req_rq <= 1'b1;
               arid <= {M_ID, rq_slot};
               araddr <= rin_addr & AMASK;
            end
            AR_REQ: if (gnt_rq) begin
               ar_st <= AR_ADDR;
               arvalid <= 1'b1;
            end
            AR_ADDR: if (arready) begin
               ar_st <= AR_IDLE;
               arvalid <= 1'b0;
               req_rq <= 1'b0;
            end
            default: ar_st <= AR_IDLE;
         endcase
   // a slot being released this cycle is never a candidate for the next return
   always_comb begin
      sel_line = '0;
      sel_err = 1'b0;
      sel_ok = 1'b0;
      for (int k = 0; k < OUTSTD; k++)
         if (nxt == SW'(k)) begin
            sel_line = line_v[k];
            sel_err = err_v[k];
            sel_ok = done_vec[k] & ~rel[k];
         end
   end
`ifdef RD_INORDER_EN
   localparam int PW = OUTSTD > 1 ? $clog2(OUTSTD) : 1;
   logic [SW-1:0] fifo [OUTSTD];
   logic [PW-1:0] wp, rp, rp_n;
   logic [PW:0] occ;
   logic push;
   assign push = arvalid & arready;
   assign rp_n = hs ? (rp == PW'(OUTSTD - 1) ? '0 : rp + 1'b1) : rp;
   assign nxt = fifo[rp_n];
   assign pick = occ > (PW+1)'(hs) && sel_ok;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         occ <= '0;
      end else begin
         if (push) wp <= wp == PW'(OUTSTD - 1) ? '0 : wp + 1'b1;
         rp <= rp_n;
         occ <= occ + (PW+1)'(push) - (PW+1)'(hs);
      end
   always_ff @(posedge clk)
      if (push) fifo[wp] <= arid[SW-1:0];
`else
   assign nxt = SW'(lowest_set(32'(done_vec & ~rel)));
   assign pick = sel_ok;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rdat_m_valid <= 1'b0;
         rdat_m_data <= '0;
         rdat_m_slot <= '0;
         rdat_m_err <= 1'b0;
      end else if (!rdat_m_valid || rdat_m_ready) begin
         rdat_m_valid <= pick;
         if (pick) begin
            rdat_m_slot <= nxt;
            rdat_m_data <= sel_line;
            rdat_m_err <= sel_err;
         end
      end
   // idle_q starts high so leaving reset does not look like a transition to idle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         idle_q <= 1'b1;
         finish_mrd <= 1'b0;
      end else begin
         idle_q <= idle_now;
         finish_mrd <= idle_now & ~idle_q;
      end
endmodule

// File: tb/tb_read_outstanding_mngr.sv
// tb_read_outstanding_mngr: directed and randomized checks of read_outstanding_mngr against a slot-level model.
module tb_read_outstanding_mngr;
   localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, BEATS = 4, OUTSTD = 2, SW = ID_W - 2;
   localparam int LINE_B = BEATS * DATA_W / 8;
   localparam logic [1:0] M_ID = 2'b00;
   logic clk = 0, rst = 1;
   logic gnt_rq = 0, arready = 0, rvalid = 0, rlast = 0, rstart_rq = 0, rdat_m_ready = 0;
   logic [ID_W-1:0] rid = '0;
   logic [DATA_W-1:0] rdata = '0;
   logic [1:0] rresp = '0;
   logic [ADDR_W-1:0] rin_addr = '0;
   logic req_rq, arvalid, rready, rbusy, rdat_m_err, rdat_m_valid, finish_mrd;
   logic [ID_W-1:0] arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0] arlen;
   logic [SW-1:0] rq_slot, rdat_m_slot;
   logic [DATA_W*BEATS-1:0] rdat_m_data;
   int errors = 0, checks = 0;
   int m_st [OUTSTD];
   int m_cnt [OUTSTD];
   bit m_err [OUTSTD];
   logic [DATA_W-1:0] m_mem [OUTSTD][BEATS];
   int m_pres;
   int m_issue [$];

   always #5 clk = ~clk;

   read_outstanding_mngr dut (
      .clk(clk), .rst(rst), .req_rq(req_rq), .gnt_rq(gnt_rq), .arvalid(arvalid), .arready(arready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .rvalid(rvalid), .rready(rready), .rid(rid),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rstart_rq(rstart_rq), .rin_addr(rin_addr),
      .rbusy(rbusy), .rq_slot(rq_slot), .rdat_m_data(rdat_m_data), .rdat_m_slot(rdat_m_slot),
      .rdat_m_err(rdat_m_err), .rdat_m_valid(rdat_m_valid), .rdat_m_ready(rdat_m_ready),
      .finish_mrd(finish_mrd)
   );

   // slot states in the model: 0 free, 1 waiting for beats, 2 line complete
   function automatic void m_reset();
      for (int i = 0; i < OUTSTD; i++) begin
         m_st[i] = 0;
         m_cnt[i] = 0;
         m_err[i] = 0;
         for (int k = 0; k < BEATS; k++) m_mem[i][k] = '0;
      end
      m_pres = -1;
      m_issue.delete();
   endfunction

   function automatic int m_lowest_free();
      for (int i = 0; i < OUTSTD; i++) if (m_st[i] == 0) return i;
      return -1;
   endfunction

   function automatic void m_alloc(input int s);
      m_st[s] = 1;
      m_cnt[s] = 0;
      m_err[s] = 0;
      m_issue.push_back(s);
   endfunction

   function automatic logic [DATA_W*BEATS-1:0] m_line(input int s);
      for (int k = 0; k < BEATS; k++) m_line[k*DATA_W +: DATA_W] = m_mem[s][k];
   endfunction

   function automatic void m_done(input int s);
      m_st[s] = 2;
`ifdef RD_INORDER_EN
      if (m_pres < 0 && m_issue.size() > 0 && m_issue[0] == s) m_pres = s;
`else
      if (m_pres < 0) m_pres = s;
`endif
   endfunction

   function automatic void m_beat(input int s, input logic [DATA_W-1:0] d, input logic [1:0] resp, input logic last);
      bool_final: begin
         bit final_beat;
         if (s >= OUTSTD || m_st[s] != 1) return;
         final_beat = m_cnt[s] == BEATS - 1;
         m_mem[s][m_cnt[s]] = d;
         m_cnt[s]++;
         if (resp != 2'b00) m_err[s] = 1;
         if (last && !final_beat) m_err[s] = 1;
         if (final_beat && !last) m_err[s] = 1;
         if (last || final_beat) m_done(s);
      end
   endfunction

   function automatic void m_release();
      m_st[m_pres] = 0;
      for (int i = 0; i < m_issue.size(); i++)
         if (m_issue[i] == m_pres) begin
            m_issue.delete(i);
            break;
         end
`ifdef RD_INORDER_EN
      m_pres = (m_issue.size() > 0 && m_st[m_issue[0]] == 2) ? m_issue[0] : -1;
`else
      m_pres = -1;
      for (int i = OUTSTD - 1; i >= 0; i--) if (m_st[i] == 2) m_pres = i;
`endif
   endfunction

   task automatic ar_phase(input int gd, input int rd, input logic [ADDR_W-1:0] ea, input int es);
      logic [ID_W-1:0] eid;
      eid = {M_ID, SW'(es)};
      checks++;
      if (req_rq !== 1'b1 || arvalid !== 1'b0) begin
         errors++;
         $display("FAIL ar_req: req_rq=%b arvalid=%b expected 1/0", req_rq, arvalid);
      end
      for (int i = 0; i < gd; i++) begin
         @(negedge clk);
         checks++;
         if (req_rq !== 1'b1 || arvalid !== 1'b0) begin
            errors++;
            $display("FAIL ar_wait_gnt: req_rq=%b arvalid=%b expected 1/0", req_rq, arvalid);
         end
      end
      gnt_rq = 1;
      @(negedge clk);
      for (int i = 0; i <= rd; i++) begin
         gnt_rq = 1'($urandom_range(0, 1));
         checks++;
         if (req_rq !== 1'b1 || arvalid !== 1'b1 || arid !== eid || araddr !== ea || arlen !== 8'(BEATS - 1)) begin
            errors++;
            $display("FAIL ar_addr: req=%b valid=%b id=%h addr=%h len=%0d expected 1/1 id=%h addr=%h len=%0d",
                     req_rq, arvalid, arid, araddr, arlen, eid, ea, BEATS - 1);
         end
         if (i == rd) arready = 1;
         @(negedge clk);
      end
      arready = 0;
      gnt_rq = 0;
      checks++;
      if (arvalid !== 1'b0 || req_rq !== 1'b0) begin
         errors++;
         $display("FAIL ar_done: arvalid=%b req_rq=%b expected 0/0", arvalid, req_rq);
      end
   endtask

   task automatic do_req(input logic [ADDR_W-1:0] a, input int gd, input int rd);
      int es;
      es = m_lowest_free();
      rstart_rq = 1;
      rin_addr = a;
      #1;
      checks++;
      if (es < 0 || rbusy !== 1'b0 || rq_slot !== SW'(es)) begin
         errors++;
         $display("FAIL accept: rbusy=%b rq_slot=%0d expected 0/%0d", rbusy, rq_slot, es);
      end
      if (es >= 0) m_alloc(es);
      @(negedge clk);
      rstart_rq = 0;
      ar_phase(gd, rd, a - (a % LINE_B), es);
   endtask

   task automatic beat(input int s, input logic [DATA_W-1:0] d, input logic [1:0] resp, input logic last);
      rvalid = 1;
      rid = {M_ID, SW'(s)};
      rdata = d;
      rresp = resp;
      rlast = last;
      #1;
      checks++;
      if (rready !== 1'b1) begin
         errors++;
         $display("FAIL rready: got %b expected 1", rready);
      end
      m_beat(s, d, resp, last);
      @(negedge clk);
      rvalid = 0;
      rlast = 0;
      rresp = '0;
   endtask

   task automatic send_line(input int s, input int n, input int last_at, input int bad_at);
      for (int k = 0; k < n; k++) beat(s, $urandom, (k == bad_at) ? 2'b10 : 2'b00, k == last_at);
   endtask

   task automatic wait_valid();
      for (int w = 0; w < 20 && rdat_m_valid !== 1'b1; w++) @(negedge clk);
   endtask

   task automatic collect(input int rdly);
      logic [DATA_W*BEATS-1:0] el;
      wait_valid();
      checks++;
      if (rdat_m_valid !== 1'b1 || m_pres < 0) begin
         errors++;
         $display("FAIL collect_timeout: valid=%b model_slot=%0d", rdat_m_valid, m_pres);
         return;
      end
      el = m_line(m_pres);
      for (int i = 0; i <= rdly; i++) begin
         checks++;
         if (rdat_m_valid !== 1'b1 || rdat_m_slot !== SW'(m_pres) || rdat_m_data !== el || rdat_m_err !== m_err[m_pres]) begin
            errors++;
            $display("FAIL line: valid=%b slot=%0d err=%b data=%h expected 1 slot=%0d err=%b data=%h",
                     rdat_m_valid, rdat_m_slot, rdat_m_err, rdat_m_data, m_pres, m_err[m_pres], el);
         end
         if (i == rdly) rdat_m_ready = 1;
         @(negedge clk);
      end
      rdat_m_ready = 0;
      m_release();
   endtask

   task automatic test_reset();
      m_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (req_rq !== 0 || arvalid !== 0 || arid !== '0 || araddr !== '0) begin
         errors++;
         $display("FAIL reset_ar: req=%b valid=%b id=%h addr=%h expected zeros", req_rq, arvalid, arid, araddr);
      end
      checks++;
      if (rdat_m_valid !== 0 || rdat_m_data !== '0 || rdat_m_slot !== '0 || rdat_m_err !== 0) begin
         errors++;
         $display("FAIL reset_ret: valid=%b slot=%0d err=%b data=%h expected zeros", rdat_m_valid, rdat_m_slot, rdat_m_err, rdat_m_data);
      end
      checks++;
      if (rbusy !== 0 || rq_slot !== '0 || rready !== 0 || finish_mrd !== 0) begin
         errors++;
         $display("FAIL reset_misc: rbusy=%b rq_slot=%0d rready=%b finish=%b expected zeros", rbusy, rq_slot, rready, finish_mrd);
      end
      checks++;
      if (arlen !== 8'd3) begin
         errors++;
         $display("FAIL reset_arlen: got %0d expected 3", arlen);
      end
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (finish_mrd !== 0 || rbusy !== 0) begin
            errors++;
            $display("FAIL reset_release: finish=%b rbusy=%b expected 0/0", finish_mrd, rbusy);
         end
      end
   endtask

   task automatic test_single();
      int pulses;
      do_req(32'h1004, 0, 0);
      beat(0, 32'hAAAA_000A, 2'b00, 0);
      beat(0, 32'hBBBB_000B, 2'b00, 0);
      beat(0, 32'hCCCC_000C, 2'b00, 0);
      beat(0, 32'hDDDD_000D, 2'b00, 1);
      wait_valid();
      checks++;
      if (rdat_m_data !== {32'hDDDD_000D, 32'hCCCC_000C, 32'hBBBB_000B, 32'hAAAA_000A} || rdat_m_err !== 0) begin
         errors++;
         $display("FAIL single_line: data=%h err=%b expected DDDD000D_CCCC000C_BBBB000B_AAAA000A/0", rdat_m_data, rdat_m_err);
      end
      collect(0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (finish_mrd === 1'b1) pulses++;
         @(negedge clk);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL finish_pulse: got %0d cycles high expected 1", pulses);
      end
   endtask

   task automatic test_out_of_order();
      int exp_first;
`ifdef RD_INORDER_EN
      exp_first = 0;
`else
      exp_first = 1;
`endif
      do_req(32'h100, 0, 0);
      do_req(32'h200, 1, 0);
      send_line(1, BEATS, BEATS - 1, -1);
      send_line(0, BEATS, BEATS - 1, -1);
      wait_valid();
      checks++;
      if (rdat_m_valid !== 1'b1 || rdat_m_slot !== SW'(exp_first)) begin
         errors++;
         $display("FAIL order_first: valid=%b slot=%0d expected 1/%0d", rdat_m_valid, rdat_m_slot, exp_first);
      end
      collect(0);
      collect(1);
   endtask

   task automatic test_full();
      do_req(32'h300, 0, 0);
      do_req(32'h400, 0, 0);
      rstart_rq = 1;
      rin_addr = 32'h50C;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (rbusy !== 1'b1 || req_rq !== 1'b0 || arvalid !== 1'b0) begin
            errors++;
            $display("FAIL full_busy: rbusy=%b req=%b arvalid=%b expected 1/0/0", rbusy, req_rq, arvalid);
         end
         @(negedge clk);
      end
      send_line(0, BEATS, BEATS - 1, -1);
      collect(0);
      #1;
      checks++;
      if (rbusy !== 1'b0 || rq_slot !== SW'(0)) begin
         errors++;
         $display("FAIL full_free: rbusy=%b rq_slot=%0d expected 0/0", rbusy, rq_slot);
      end
      m_alloc(0);
      @(negedge clk);
      rstart_rq = 0;
      ar_phase(0, 0, 32'h500, 0);
      send_line(1, BEATS, BEATS - 1, -1);
      send_line(0, BEATS, BEATS - 1, -1);
      collect(0);
      collect(2);
   endtask

   task automatic test_errors();
      do_req(32'h800, 0, 0);
      send_line(0, BEATS, BEATS - 1, 1);
      wait_valid();
      checks++;
      if (rdat_m_err !== 1'b1) begin
         errors++;
         $display("FAIL err_resp: err=%b expected 1", rdat_m_err);
      end
      collect(0);
      do_req(32'h900, 0, 0);
      send_line(0, 3, 2, -1);
      collect(0);
      do_req(32'hA00, 0, 0);
      send_line(0, BEATS + 1, BEATS, -1);
      collect(0);
   endtask

   task automatic test_ar_delay();
      do_req(32'h2468, 5, 3);
      send_line(0, BEATS, BEATS - 1, -1);
      collect(0);
   endtask

   task automatic test_backpressure_foreign();
      do_req(32'h3000, 0, 0);
      rvalid = 1;
      rid = {2'b01, 2'b00};
      rdata = 32'hDEAD_BEEF;
      rlast = 1;
      #1;
      checks++;
      if (rready !== 1'b0) begin
         errors++;
         $display("FAIL foreign_rready: got %b expected 0", rready);
      end
      @(negedge clk);
      rvalid = 0;
      rlast = 0;
      send_line(0, BEATS, BEATS - 1, -1);
      collect(10);
      @(negedge clk);
      checks++;
      if (rdat_m_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_drop: got %b expected 0", rdat_m_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_req(32'hB00, 0, 0);
      send_line(0, 2, -1, -1);
      rst = 1;
      #1;
      m_reset();
      checks++;
      if (req_rq !== 0 || arvalid !== 0 || araddr !== '0 || rdat_m_valid !== 0 || rdat_m_data !== '0 || rbusy !== 0 || finish_mrd !== 0) begin
         errors++;
         $display("FAIL midreset_out: req=%b arvalid=%b addr=%h valid=%b data=%h rbusy=%b finish=%b expected zeros",
                  req_rq, arvalid, araddr, rdat_m_valid, rdat_m_data, rbusy, finish_mrd);
      end
      @(negedge clk);
      rst = 0;
      beat(0, 32'h1111_1111, 2'b00, 0);
      beat(0, 32'h2222_2222, 2'b00, 1);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rdat_m_valid !== 0 || finish_mrd !== 0) begin
            errors++;
            $display("FAIL stale_drop: valid=%b finish=%b expected 0/0", rdat_m_valid, finish_mrd);
         end
         @(negedge clk);
      end
      do_req(32'hC04, 0, 1);
      send_line(0, 3, 2, -1);
      collect(0);
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         int n;
         bit swap;
         n = $urandom_range(1, 2);
         swap = 1'($urandom_range(0, 1));
         for (int j = 0; j < n; j++) do_req($urandom, $urandom_range(0, 3), $urandom_range(0, 3));
         for (int j = 0; j < n; j++) begin
            int s;
            s = (n == 2 && swap) ? 1 - j : j;
            for (int k = 0; k < BEATS; k++)
               beat(s, $urandom, ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00, k == BEATS - 1);
         end
         for (int j = 0; j < n; j++) collect($urandom_range(0, 3));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_out_of_order();
      test_full();
      test_errors();
      test_ar_delay();
      test_backpressure_foreign();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
